// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex-display scan controller: a prescaler steps a one-hot digit select
// and a shadow register commits to the display only at frame wrap. Define
// SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dig_en,
  input  logic                load,
  output logic [3:0]          data,
  output logic                blank,
  output logic [NDIG-1:0]     dig_sel,
  output logic                frame,
  output logic                upd_done
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   disp_en_q, disp_en_d;
  logic [NDIG-1:0]   shadow_en_q, shadow_en_d;
  logic              pending_q, pending_d;
  logic              slot_end;
  logic              wrap;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    disp_en_d   = disp_en_q;
    shadow_d    = shadow_q;
    shadow_en_d = shadow_en_q;
    pending_d   = pending_q;

    slot_end = (cnt_q == CNT_MAX);
    wrap     = slot_end && (idx_q == IDX_MAX);

    if (slot_end) begin
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The display only ever changes on the frame boundary, so a frame never tears.
    if (wrap && pending_q) begin
      disp_d    = shadow_q;
      disp_en_d = shadow_en_q;
    end

    // A load in the wrap cycle lands in the shadow after the old shadow was committed,
    // and keeps pending set so it shows next frame.
    if (load) begin
      shadow_d    = value;
      shadow_en_d = dig_en;
      pending_d   = 1'b1;
    end else if (wrap) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the display/shadow are plain registers, not a memory, so resetting them is cheap and wanted.
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      shadow_q    <= '0;
      disp_en_q   <= '1;
      shadow_en_q <= '1;
      pending_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      shadow_q    <= shadow_d;
      disp_en_q   <= disp_en_d;
      shadow_en_q <= shadow_en_d;
      pending_q   <= pending_d;
    end
  end

  // Outputs decode registered state only.
  logic lz_blank;

`ifdef SEG_SCAN_LZB_EN
  logic [NDIG-1:0] zero_from;

  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run          = run & (disp_q[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  assign lz_blank = (idx_q != '0) && zero_from[idx_q];
`else
  assign lz_blank = 1'b0;
`endif

  assign data     = disp_q[{idx_q, 2'b00} +: 4];
  assign blank    = ~disp_en_q[idx_q] | lz_blank;
  assign dig_sel  = NDIG'(1) << idx_q;
  assign frame    = wrap;
  assign upd_done = wrap & pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=8, SCAN_DIV=4): a frame-level reference
// model pushes expected outputs each cycle and a negedge monitor compares them.
module tb_seg_scan_ctrl;

  localparam int NDIG     = 8;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = NDIG * SCAN_DIV;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*NDIG-1:0]   value;
  logic [NDIG-1:0]     dig_en;
  logic                load;
  logic [3:0]          data;
  logic                blank;
  logic [NDIG-1:0]     dig_sel;
  logic                frame;
  logic                upd_done;

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .dig_en(dig_en), .load(load),
    .data(data), .blank(blank), .dig_sel(dig_sel), .frame(frame), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sel;
    logic [3:0] data;
    logic       blank;
    logic       frame;
    logic       upd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_upd = 0;

  // Reference model: time-in-frame plus displayed/shadow words.
  int          m_t;
  logic [31:0] m_disp, m_shadow;
  logic [7:0]  m_den, m_sen;
  bit          m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   d;
    bit   lz;
    d  = m_t / SCAN_DIV;
    lz = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    lz = (d > 0) && ((m_disp >> (4 * d)) == 32'd0);
`endif
    e.sel   = 8'(1 << d);
    e.data  = 4'((m_disp >> (4 * d)) & 32'hF);
    e.blank = !m_den[d] || lz;
    e.frame = (m_t == FRAME - 1);
    e.upd   = e.frame && m_pend;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit ld, input logic [31:0] v, input logic [7:0] en);
    bit w;
    if (r) begin
      m_t = 0; m_disp = '0; m_shadow = '0; m_den = '1; m_sen = '1; m_pend = 0;
    end else begin
      w = (m_t == FRAME - 1);
      if (w && m_pend) begin
        m_disp = m_shadow;
        m_den  = m_sen;
      end
      if (ld) begin
        m_shadow = v; m_sen = en; m_pend = 1;
      end else if (w) begin
        m_pend = 0;
      end
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then publish the expectation.
  task automatic cyc(input bit r, input bit ld, input logic [31:0] v, input logic [7:0] en);
    rst = r; load = ld; value = v; dig_en = en;
    model_step(r, ld, v, en);
    @(posedge clk);
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom, 8'($urandom));
  endtask

  task automatic run_until(input int t);
    for (int i = 0; i < 2 * FRAME && m_t != t; i++) cyc(0, 0, $urandom, 8'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dig_sel",  32'(dig_sel),  32'(e.sel));
      check("data",     32'(data),     32'(e.data));
      check("blank",    32'(blank),    32'(e.blank));
      check("frame",    32'(frame),    32'(e.frame));
      check("upd_done", 32'(upd_done), 32'(e.upd));
      if (upd_done === 1'b1) n_upd++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          upd_before;

    // Reset, then a full frame with idle inputs: dig_sel walks, frame at t=31 only.
    for (int i = 0; i < 3; i++) cyc(1, 0, $urandom, 8'($urandom));
    idle(FRAME + 2);

    // Load mid-frame; shown only after the wrap.
    run_until(10);
    cyc(0, 1, 32'h1234_5678, 8'hFF);
    run_until(0);
    idle(FRAME);

    // Two loads in one frame: only the last is shown, one upd_done.
    upd_before = n_upd;
    run_until(3);
    cyc(0, 1, 32'hAAAA_0000, 8'hFF);
    run_until(17);
    cyc(0, 1, 32'h0000_BBBB, 8'hFF);
    run_until(0);
    idle(FRAME);
    @(negedge clk); #1;
    check("single_upd_done", 32'(n_upd - upd_before), 32'd1);

    // Per-digit enables.
    cyc(0, 1, 32'h0000_0000, 8'h0F);
    run_until(0);
    idle(FRAME);

    // Leading-zero candidate pattern.
    cyc(0, 1, 32'h0000_0A05, 8'hFF);
    run_until(0);
    idle(FRAME);

    // Load in the wrap cycle: old shadow commits now, new one next frame.
    cyc(0, 1, 32'hCAFE_0001, 8'hFF);
    run_until(FRAME - 1);
    cyc(0, 1, 32'h0BAD_F00D, 8'hF0);
    idle(2 * FRAME);

    // Reset at idx=5 with a pending load discards it.
    run_until(4);
    cyc(0, 1, 32'h7777_7777, 8'hFF);
    run_until(5 * SCAN_DIV + 1);
    cyc(1, 0, $urandom, 8'($urandom));
    idle(FRAME + 2);

    // Randomized traffic, biased towards leading-zero values, with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 7));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, v, 8'($urandom));
    end
    idle(2);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 8, giving the number of display digits (legal 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, giving the clocks per digit slot (legal >= 2).
REQ-003 The block SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port value, input, width 4*NDIG: hex value to show; nibble i maps to digit i, with digit 0 = value[3:0].
REQ-006 The block SHALL have port dig_en, input, width NDIG: per-digit enable, captured together with value.
REQ-007 The block SHALL have port load, input, width 1: when high, capture value/dig_en into the shadow registers.
REQ-008 The block SHALL have port data, output, width 4: nibble of the currently selected digit, feeding the downstream hex-to-segment decoder.
REQ-009 The block SHALL have port blank, output, width 1: high when the current digit must be dark.
REQ-010 The block SHALL have port dig_sel, output, width NDIG: one-hot, active-high digit select.
REQ-011 The block SHALL have port frame, output, width 1: one-cycle pulse at the end of the last digit slot.
REQ-012 The block SHALL have port upd_done, output, width 1: one-cycle pulse when the shadow is committed to the display.

Function
REQ-013 Prescaler cnt SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL return to 0 and advance digit index idx.
REQ-014 idx SHALL step 0,1,..,NDIG-1 and then wrap to 0; each digit SHALL be held for exactly SCAN_DIV cycles.
REQ-015 dig_sel, data and blank SHALL be decoded from registered state only (idx, disp, disp_en), with no combinational path from inputs.
REQ-016 data SHALL equal disp nibble idx; dig_sel SHALL equal 1<<idx.
REQ-017 blank SHALL equal ~disp_en[idx], OR'ed with the leading-zero term when that feature is compiled in (REQ-026).
REQ-018 load=1 SHALL write shadow<=value and shadow_en<=dig_en, and SHALL set pending; repeated loads before commit SHALL keep only the last value.
REQ-019 The wrap cycle is cnt=SCAN_DIV-1 with idx=NDIG-1; frame SHALL be 1 in exactly that cycle.
REQ-020 In the wrap cycle with pending=1: disp<=shadow, disp_en<=shadow_en, pending<=0, and upd_done=1 in the same cycle as frame.
REQ-021 Load and wrap in the same cycle: the commit SHALL use the old shadow; the new value SHALL be stored in shadow and pending SHALL stay 1, so it commits next frame.
REQ-022 The displayed content SHALL never change mid-frame (no tearing).

Reset
REQ-023 rst=1 SHALL force cnt=0, idx=0, disp=0, shadow=0, disp_en=shadow_en=all ones, pending=0.
REQ-024 The cycle after rst: dig_sel=1 (bit 0), data=0, blank=0, frame=0, upd_done=0.
REQ-025 rst asserted mid-frame SHALL discard any pending load; rst SHALL have priority over load.

Configuration
REQ-026 Macro SEG_SCAN_LZB_EN defined: digit i>0 SHALL be blanked when disp nibbles i..NDIG-1 are all zero; digit 0 SHALL never be zero-blanked.
REQ-027 Macro SEG_SCAN_LZB_EN undefined: blank SHALL depend on disp_en only.

Verification (NDIG=8, SCAN_DIV=4)
REQ-028 Release rst -> dig_sel 0x01,0x02,..,0x80,0x01, each held 4 cycles; frame high only at cycle 31.
REQ-029 load 0x12345678 at cycle 10 -> data unchanged (0) until wrap; frame=upd_done=1 at cycle 31; then digit0 data=8, digit7 data=1.
REQ-030 load 0xAAAA0000 then 0x0000BBBB in the same frame -> only 0x0000BBBB is shown, with exactly one upd_done.
REQ-031 load 0x00000000, dig_en=0x0F -> blank=1 during digits 4..7 and 0 during digits 0..3.
REQ-032 value 0x00000A05, dig_en=0xFF -> with SEG_SCAN_LZB_EN, digits 3..7 blank and 0..2 lit; without it, no digit blank.
REQ-033 rst at idx=5 with pending=1 -> next cycle dig_sel=0x01, data=0; no upd_done at the following wrap.
